// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM arbiter slice.
//   - size encodings (mem_u_b_h_w): bit0 = half, bit1 = word, bit2 = unsigned
//   - arbiter FSM state and command-source encodings
//   - nbytes(): beat size in bytes for a size code
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_DMA_BURST = 1'b1
    } state_e;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_DMA = 1'b1
    } src_e;

    function automatic logic [2:0] nbytes(input logic [2:0] size);
        if (size[1]) begin
            return 3'd4;
        end else if (size[0]) begin
            return 3'd2;
        end
        return 3'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-RAM arbiter (one instance per requester).
//   master: requester drives req/we/addr/wdata/size/lock, sees gnt/rvalid/rdata/err
//   slave : arbiter side of the same signals
// lock is only meaningful on the DMA port; the CPU side ties it low.
interface dmem_arbiter_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        lock;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, size, lock,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, size, lock,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/dmem_range_chk.sv
// Range check for one RAM access.
//   addr : byte address of the access
//   size : mem_u_b_h_w size code
//   err  : 1 when the address lies above the RAM or the access would run past its end
module dmem_range_chk
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    output logic        err
);

    localparam int unsigned SUM_W = ADDR_W + 1;

    // One extra bit so that an access ending exactly at the top is not mistaken for a wrap.
    logic [ADDR_W:0] end_addr;

    assign end_addr = {1'b0, addr[ADDR_W-1:0]} + SUM_W'(nbytes(size));

    // end_addr > 2^ADDR_W <=> top bit set and any lower bit set.
    assign err = (|addr[31:ADDR_W]) | (end_addr[ADDR_W] & (|end_addr[ADDR_W-1:0]));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port byte-addressable data RAM.
//   clk, rst      : clock, asynchronous active-high reset
//   cpu, dma      : requester buses (dma.lock requests burst ownership)
//   ram_addr/din  : RAM address and write data
//   ram_we        : RAM write enable (the RAM writes on the falling edge)
//   ram_size      : RAM mem_u_b_h_w size code
//   ram_dout      : RAM combinational, already-extended read data
// Pipeline: grant -> command register (drives RAM) -> response register (rvalid pulse).
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_arbiter_if.slave      cpu,
    dmem_arbiter_if.slave      dma,
    output logic [31:0]        ram_addr,
    output logic [31:0]        ram_din,
    output logic               ram_we,
    output logic [2:0]         ram_size,
    input  logic [31:0]        ram_dout
);

    localparam logic [3:0] MAX_BEAT = 4'(MAX_BURST);

    state_e      state_q, state_d;
    logic        rr_q, rr_d;           // 0: CPU preferred on conflict
    logic [3:0]  beat_q, beat_d;
    logic        cpu_gnt, dma_gnt, accept;

    logic [31:0] g_addr, g_wdata;
    logic [2:0]  g_size;
    logic        g_we, g_err;

    logic        cmd_valid_q, cmd_we_q, cmd_err_q;
    src_e        cmd_src_q;
    logic [31:0] cmd_addr_q, cmd_wdata_q;
    logic [2:0]  cmd_size_q;

    logic        rsp_valid_q, rsp_err_q;
    src_e        rsp_src_q;
    logic [31:0] rsp_data_q;

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        state_d = state_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu.req && dma.req) begin
                    cpu_gnt = ~rr_q;
                    dma_gnt = rr_q;
                    rr_d    = ~rr_q;   // point at the loser
                end else begin
                    cpu_gnt = cpu.req;
                    dma_gnt = dma.req;
                end
                if (dma_gnt && dma.lock) begin
                    if (MAX_BEAT > 4'd1) begin
                        state_d = ST_DMA_BURST;
                        beat_d  = 4'd1;
                    end else begin
                        rr_d = 1'b0;   // a one-beat burst is already exhausted
                    end
                end
            end
            ST_DMA_BURST: begin
                dma_gnt = dma.req;
                if (dma_gnt) begin
                    beat_d = beat_q + 4'd1;
                    if (!dma.lock || beat_d == MAX_BEAT) begin
                        state_d = ST_IDLE;
                        rr_d    = 1'b0;
                        beat_d  = 4'd0;
                    end
                end else if (!dma.lock) begin
                    state_d = ST_IDLE;
                    rr_d    = 1'b0;
                    beat_d  = 4'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            beat_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    assign cpu.gnt = cpu_gnt;
    assign dma.gnt = dma_gnt;
    assign accept  = cpu_gnt | dma_gnt;

    // Granted request; all zero when nothing is accepted so the command stage clears.
    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_size  = '0;
        g_we    = 1'b0;
        if (dma_gnt) begin
            g_addr  = dma.addr;
            g_wdata = dma.wdata;
            g_size  = dma.size;
            g_we    = dma.we;
        end else if (cpu_gnt) begin
            g_addr  = cpu.addr;
            g_wdata = cpu.wdata;
            g_size  = cpu.size;
            g_we    = cpu.we;
        end
    end

    dmem_range_chk #(
        .ADDR_W (ADDR_W)
    ) u_range_chk (
        .addr (g_addr),
        .size (g_size),
        .err  (g_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            cmd_src_q   <= SRC_CPU;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_size_q  <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            cmd_valid_q <= accept;
            cmd_src_q   <= dma_gnt ? SRC_DMA : SRC_CPU;
            cmd_we_q    <= g_we;
            cmd_addr_q  <= g_addr;
            cmd_wdata_q <= g_wdata;
            cmd_size_q  <= g_size;
            cmd_err_q   <= accept & g_err;
        end
    end

    // Erroneous accesses are steered to address 0 with the write suppressed.
    assign ram_we   = cmd_valid_q & cmd_we_q & ~cmd_err_q;
    assign ram_addr = cmd_err_q ? 32'd0 : cmd_addr_q;
    assign ram_din  = cmd_wdata_q;
    assign ram_size = cmd_size_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= SRC_CPU;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= cmd_valid_q;
            rsp_src_q   <= cmd_src_q;
            rsp_data_q  <= (cmd_valid_q & ~cmd_we_q & ~cmd_err_q) ? ram_dout : 32'd0;
            rsp_err_q   <= cmd_valid_q & cmd_err_q;
        end
    end

    assign cpu.rvalid = rsp_valid_q & (rsp_src_q == SRC_CPU);
    assign dma.rvalid = rsp_valid_q & (rsp_src_q == SRC_DMA);
    assign cpu.rdata  = cpu.rvalid ? rsp_data_q : 32'd0;
    assign dma.rdata  = dma.rvalid ? rsp_data_q : 32'd0;
    assign cpu.err    = cpu.rvalid & rsp_err_q;
    assign dma.err    = dma.rvalid & rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge-writing byte RAM model.
module tb_dmem_arbiter;
    import mem_pkg::*;

    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic        ram_we;
    logic [2:0]  ram_size;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter_if cpu_if ();
    dmem_arbiter_if dma_if ();

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (cpu_if),
        .dma      (dma_if),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_size (ram_size),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model: little-endian, writes on negedge, combinational extended read.
    logic [7:0] mem [0:127];
    logic [6:0] ra;
    logic [7:0] b0, b1, b2, b3;
    assign ra = ram_addr[6:0];
    assign b0 = mem[ra];
    assign b1 = mem[ra + 7'd1];
    assign b2 = mem[ra + 7'd2];
    assign b3 = mem[ra + 7'd3];

    always @(negedge clk) begin
        if (ram_we) begin
            mem[ra] <= ram_din[7:0];
            if (ram_size[0] || ram_size[1]) mem[ra + 7'd1] <= ram_din[15:8];
            if (ram_size[1]) begin
                mem[ra + 7'd2] <= ram_din[23:16];
                mem[ra + 7'd3] <= ram_din[31:24];
            end
        end
    end

    always_comb begin
        if (ram_size[1]) ram_dout = {b3, b2, b1, b0};
        else if (ram_size[0]) ram_dout = {{16{~ram_size[2] & b1[7]}}, b1, b0};
        else ram_dout = {{24{~ram_size[2] & b0[7]}}, b0};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit use_dma, input bit req, input bit we, input bit lock,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size);
        if (use_dma) begin
            dma_if.req = req; dma_if.we = we; dma_if.lock = lock;
            dma_if.addr = addr; dma_if.wdata = wdata; dma_if.size = size;
        end else begin
            cpu_if.req = req; cpu_if.we = we; cpu_if.lock = 1'b0;
            cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.size = size;
        end
    endtask

    // One isolated access; called and returns at posedge+1.
    task automatic single(input bit use_dma, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] size,
                          output bit g, output bit rw, output logic [31:0] ras,
                          output bit rv_early, output bit rv, output bit rv_other,
                          output logic [31:0] rd, output bit er);
        drive(use_dma, 1'b1, we, 1'b0, addr, wdata, size);
        @(negedge clk);
        g = use_dma ? dma_if.gnt : cpu_if.gnt;
        step();
        drive(use_dma, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        rw       = ram_we;
        ras      = ram_addr;
        rv_early = cpu_if.rvalid | dma_if.rvalid;
        step();
        rv       = use_dma ? dma_if.rvalid : cpu_if.rvalid;
        rv_other = use_dma ? cpu_if.rvalid : dma_if.rvalid;
        rd       = use_dma ? dma_if.rdata : cpu_if.rdata;
        er       = use_dma ? dma_if.err : cpu_if.err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cpu_if.rvalid, cpu_if.err, dma_if.rvalid, dma_if.err, ram_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {cpu_if.rvalid, cpu_if.err, dma_if.rvalid, dma_if.err, ram_we});
        end
        n_checks++;
        if ({cpu_if.rdata, dma_if.rdata} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h want 0 0", cpu_if.rdata, dma_if.rdata);
        end
        n_checks++;
        if ({ram_addr, ram_din, ram_size} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_ram: got addr %h din %h size %b want 0", ram_addr, ram_din, ram_size);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_store_load();
        bit g, rw, rve, rv, rvo, er;
        logic [31:0] rd, ras;
        single(1'b0, 1'b1, 32'h10, 32'h11223344, SZ_W, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if ({g, rw, rve, rv, rvo, er} !== 6'b110100) begin
            n_fail++;
            $display("FAIL st_flags gnt/we/early/rv/other/err: got %b want 110100",
                     {g, rw, rve, rv, rvo, er});
        end
        n_checks++;
        if (rd !== 32'd0) begin n_fail++; $display("FAIL st_rdata: got %h want 0", rd); end
        step();
        n_checks++;
        if (cpu_if.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL st_rvalid_pulse: got %b want 0", cpu_if.rvalid);
        end
        single(1'b0, 1'b0, 32'h10, 32'd0, SZ_W, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if ({g, rw, rv, er} !== 4'b1010) begin
            n_fail++; $display("FAIL ld_flags gnt/we/rv/err: got %b want 1010", {g, rw, rv, er});
        end
        n_checks++;
        if (rd !== 32'h11223344) begin
            n_fail++; $display("FAIL ld_rdata: got %h want 11223344", rd);
        end
    endtask

    task automatic test_alternate();
        logic [7:0] cg_hist;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, SZ_W);
                drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, SZ_W);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
                drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
            end
            @(negedge clk);
            cg_hist[i] = cpu_if.gnt;
            if (i < 6) begin
                n_checks++;
                if ({cpu_if.gnt, dma_if.gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL alt_gnt[%0d]: got cpu/dma %b%b want %b", i, cpu_if.gnt,
                             dma_if.gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            if (i >= 2) begin
                n_checks++;
                if ({cpu_if.rvalid, dma_if.rvalid} !== (((i - 2) % 2 == 0) ? 2'b10 : 2'b01)
                    || (cpu_if.rdata | dma_if.rdata) !== 32'h11223344) begin
                    n_fail++;
                    $display("FAIL alt_rsp[%0d]: got rv %b%b data %h want %b 11223344", i,
                             cpu_if.rvalid, dma_if.rvalid, cpu_if.rdata | dma_if.rdata,
                             ((i - 2) % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            step();
        end
    endtask

    // exp_cpu bit i: CPU expected to win cycle i; otherwise DMA.
    task automatic run_grants(input string name, input int n, input logic [7:0] cpu_from,
                              input logic [7:0] lock_pat, input logic [7:0] exp_cpu);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 1'b0, lock_pat[i], 32'h10, 32'd0, SZ_W);
            drive(1'b0, cpu_from[i], 1'b0, 1'b0, 32'h10, 32'd0, SZ_W);
            @(negedge clk);
            n_checks++;
            if ({cpu_if.gnt, dma_if.gnt} !== (exp_cpu[i] ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL %s[%0d]: got cpu/dma %b%b want %b", name, i, cpu_if.gnt,
                         dma_if.gnt, exp_cpu[i] ? 2'b10 : 2'b01);
            end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        repeat (3) step();
    endtask

    task automatic test_burst();
        // DMA alone in cycle 0 with lock, CPU joins from cycle 1: DDDD C DD
        run_grants("burst", 7, 8'b0111_1110, 8'b0111_1111, 8'b0001_0000);
        // Idle cycle without lock left the burst with rr on CPU.
        run_grants("burst_exit", 1, 8'b0000_0001, 8'b0000_0000, 8'b0000_0001);
    endtask

    task automatic test_lock_drop();
        // Locked beat, then a beat with lock dropped: CPU wins the next conflict. D D C D
        run_grants("lockdrop", 4, 8'b0000_1110, 8'b0000_0001, 8'b0000_0100);
    endtask

    task automatic test_sign_range();
        bit g, rw, rve, rv, rvo, er;
        logic [31:0] rd, ras;
        single(1'b0, 1'b1, 32'h7F, 32'h00000080, SZ_B, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if ({rw, er} !== 2'b10) begin
            n_fail++; $display("FAIL top_byte_store we/err: got %b want 10", {rw, er});
        end
        single(1'b0, 1'b0, 32'h7F, 32'd0, SZ_B, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
            n_fail++; $display("FAIL ld_sb: got %h err %b want FFFFFF80 err 0", rd, er);
        end
        single(1'b1, 1'b0, 32'h7F, 32'd0, SZ_BU, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if (rd !== 32'h00000080 || rv !== 1'b1 || rvo !== 1'b0) begin
            n_fail++;
            $display("FAIL dma_ld_bu: got %h rv %b other %b want 00000080 1 0", rd, rv, rvo);
        end
        single(1'b0, 1'b0, 32'h7E, 32'd0, SZ_H, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if (rd !== 32'hFFFF8000 || er !== 1'b0) begin
            n_fail++; $display("FAIL ld_h_top: got %h err %b want FFFF8000 err 0", rd, er);
        end
        single(1'b0, 1'b0, 32'h7F, 32'd0, SZ_HU, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL ld_hu_cross: got err %b rd %h want 1 0", er, rd);
        end
        single(1'b0, 1'b0, 32'h7E, 32'd0, SZ_W, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if ({rv, er, rw} !== 3'b110 || rd !== 32'd0 || ras !== 32'd0) begin
            n_fail++;
            $display("FAIL ld_w_cross rv/err/we: got %b rd %h addr %h want 110 0 0",
                     {rv, er, rw}, rd, ras);
        end
    endtask

    task automatic test_out_of_range();
        bit g, rw, rve, rv, rvo, er;
        logic [31:0] rd, ras;
        single(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, SZ_W, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if ({g, rw, rv, er} !== 4'b1011 || ras !== 32'd0) begin
            n_fail++;
            $display("FAIL oor_store gnt/we/rv/err: got %b addr %h want 1011 0", {g, rw, rv, er}, ras);
        end
        single(1'b1, 1'b0, 32'h0, 32'd0, SZ_W, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            n_fail++; $display("FAIL oor_readback: got %h err %b want 0 err 0", rd, er);
        end
    endtask

    task automatic test_reset_mid();
        bit g, rw, rve, rv, rvo, er;
        logic [31:0] rd, ras;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFEF00D, SZ_W);
        @(negedge clk);
        n_checks++;
        if (cpu_if.gnt !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_gnt: got %b want 1", cpu_if.gnt);
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_we: got %b want 0", ram_we);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (cpu_if.rvalid !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_rvalid[%0d]: got %b want 0", i, cpu_if.rvalid);
            end
            step();
        end
        single(1'b0, 1'b0, 32'h10, 32'd0, SZ_W, g, rw, ras, rve, rv, rvo, rd, er);
        n_checks++;
        if (rd !== 32'h11223344) begin
            n_fail++; $display("FAIL rstmid_readback: got %h want 11223344", rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        test_reset();
        test_store_load();
        test_alternate();
        test_burst();
        test_lock_drop();
        test_sign_range();
        test_out_of_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
